shifter_pipelined: RTL and testbench

Parametrised, pipelined barrel shifter for the ALU. One registered stage per shift level, so throughput is one operation per cycle. Supports logical left/right shifts, arithmetic right shifts and left/right rotates. Uses a valid/ready handshake with backpressure and carries a sideband tag (e.g. destination register index) alongside each operation.

---
 rtl/shifter_pkg.sv | 15 +
 rtl/shifter_pipe_stage.sv | 73 +++++++
 rtl/shifter_pipelined.sv | 88 ++++++++
 tb/tb_shifter_pipelined.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/shifter_pkg.sv
// Shared types for the pipelined barrel shifter.
// Holds the shift opcode enum and its width.
package shifter_pkg;

  localparam int SHIFT_OP_W = 3;

  typedef enum logic [SHIFT_OP_W-1:0] {
    SLL = 3'd0,
    SRL = 3'd1,
    SRA = 3'd2,
    ROL = 3'd3,
    ROR = 3'd4
  } shift_op_t;

endpackage

// File: rtl/shifter_pipe_stage.sv
// One level of the pipelined barrel shifter.
// Ports: clk_i/rst_i, en_i (advance), *_i from the previous
// level, *_o registered towards the next level. Applies a
// fixed shift of 2**stage when bit `stage` of amt_i is set.
module shifter_pipe_stage
  import shifter_pkg::*;
#(
  parameter int nb_bits_data  = 32,
  parameter int stage         = 0,
  parameter int nb_bits_shift = 5,
  parameter int nb_bits_tag   = 5
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     en_i,
  input  logic                     valid_i,
  input  logic [SHIFT_OP_W-1:0]    op_i,
  input  logic [nb_bits_data-1:0]  data_i,
  input  logic [nb_bits_shift-1:0] amt_i,
  input  logic [nb_bits_tag-1:0]   tag_i,
  input  logic                     sign_i,
  output logic                     valid_o,
  output logic [SHIFT_OP_W-1:0]    op_o,
  output logic [nb_bits_data-1:0]  data_o,
  output logic [nb_bits_shift-1:0] amt_o,
  output logic [nb_bits_tag-1:0]   tag_o,
  output logic                     sign_o
);

  localparam int W = nb_bits_data;
  localparam int S = 2 ** stage;
  localparam logic [W-1:0] ONES = '1;

  logic [W-1:0] shifted;

  // sign_i is the original operand MSB, so SRA fill is
  // independent of what earlier levels did to the data.
  always_comb begin
    shifted = data_i;
    if (amt_i[stage]) begin
      unique case (shift_op_t'(op_i))
        SLL: shifted = data_i << S;
        SRL: shifted = data_i >> S;
        SRA: shifted = (data_i >> S)
                     | (sign_i ? ~(ONES >> S) : '0);
        ROL: shifted = (data_i << S)
                     | (data_i >> (W - S));
        ROR: shifted = (data_i >> S)
                     | (data_i << (W - S));
        default: shifted = data_i;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_o <= 1'b0;
      op_o    <= '0;
      data_o  <= '0;
      amt_o   <= '0;
      tag_o   <= '0;
      sign_o  <= 1'b0;
    end else if (en_i) begin
      valid_o <= valid_i;
      op_o    <= op_i;
      data_o  <= shifted;
      amt_o   <= amt_i;
      tag_o   <= tag_i;
      sign_o  <= sign_i;
    end
  end

endmodule

// File: rtl/shifter_pipelined.sv
// Pipelined barrel shifter, one register level per amount bit.
// Ports: valid_i/ready_o input handshake with op_i, data_i,
// shift_value_i, tag_i; valid_o/ready_i output handshake with
// data_o (zero when idle) and tag_o. Global stall on backpressure.
module shifter_pipelined
  import shifter_pkg::*;
#(
  parameter int nb_bits_data  = 32,
  parameter int nb_bits_shift = 5,
  parameter int nb_bits_tag   = 5
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     valid_i,
  output logic                     ready_o,
  input  logic [SHIFT_OP_W-1:0]    op_i,
  input  logic [nb_bits_data-1:0]  data_i,
  input  logic [nb_bits_shift-1:0] shift_value_i,
  input  logic [nb_bits_tag-1:0]   tag_i,
  output logic                     valid_o,
  input  logic                     ready_i,
  output logic [nb_bits_data-1:0]  data_o,
  output logic [nb_bits_tag-1:0]   tag_o
);

  localparam int N = nb_bits_shift;

  if (2 ** nb_bits_shift > nb_bits_data) begin : g_bad_shift
    $error("2**nb_bits_shift must not exceed nb_bits_data");
  end
  if (nb_bits_tag < 1) begin : g_bad_tag
    $error("nb_bits_tag must be at least 1");
  end

  logic                     valid_c [0:N];
  logic [SHIFT_OP_W-1:0]    op_c    [0:N];
  logic [nb_bits_data-1:0]  data_c  [0:N];
  logic [nb_bits_shift-1:0] amt_c   [0:N];
  logic [nb_bits_tag-1:0]   tag_c   [0:N];
  logic                     sign_c  [0:N];

  logic advance;

  // Whole pipe moves together; it only freezes when a finished
  // result is sitting at the output and nobody takes it.
  assign advance = !valid_c[N] || ready_i;
  assign ready_o = advance;

  assign valid_c[0] = valid_i;
  assign op_c[0]    = op_i;
  assign data_c[0]  = data_i;
  assign amt_c[0]   = shift_value_i;
  assign tag_c[0]   = tag_i;
  assign sign_c[0]  = data_i[nb_bits_data-1];

  for (genvar k = 0; k < N; k++) begin : g_stage
    shifter_pipe_stage #(
      .nb_bits_data  (nb_bits_data),
      .stage         (k),
      .nb_bits_shift (nb_bits_shift),
      .nb_bits_tag   (nb_bits_tag)
    ) u_stage (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .en_i    (advance),
      .valid_i (valid_c[k]),
      .op_i    (op_c[k]),
      .data_i  (data_c[k]),
      .amt_i   (amt_c[k]),
      .tag_i   (tag_c[k]),
      .sign_i  (sign_c[k]),
      .valid_o (valid_c[k+1]),
      .op_o    (op_c[k+1]),
      .data_o  (data_c[k+1]),
      .amt_o   (amt_c[k+1]),
      .tag_o   (tag_c[k+1]),
      .sign_o  (sign_c[k+1])
    );
  end

  assign valid_o = valid_c[N];
  assign data_o  = valid_c[N] ? data_c[N] : '0;
  assign tag_o   = tag_c[N];

  logic unused_tail;
  assign unused_tail = ^{op_c[N], amt_c[N], sign_c[N]};

endmodule

// File: tb/tb_shifter_pipelined.sv
// Scoreboard bench for shifter_pipelined.
// Directed cases, streams, backpressure and mid-flight reset.
module tb_shifter_pipelined;

  localparam int W = 32;
  localparam int N = 5;
  localparam int T = 5;

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic         valid_i;
  logic         ready_o;
  logic [2:0]   op_i;
  logic [W-1:0] data_i;
  logic [N-1:0] shift_value_i;
  logic [T-1:0] tag_i;
  logic         valid_o;
  logic         ready_i;
  logic [W-1:0] data_o;
  logic [T-1:0] tag_o;

  always #5 clk_i = ~clk_i;

  shifter_pipelined #(
    .nb_bits_data  (W),
    .nb_bits_shift (N),
    .nb_bits_tag   (T)
  ) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .valid_i       (valid_i),
    .ready_o       (ready_o),
    .op_i          (op_i),
    .data_i        (data_i),
    .shift_value_i (shift_value_i),
    .tag_i         (tag_i),
    .valid_o       (valid_o),
    .ready_i       (ready_i),
    .data_o        (data_o),
    .tag_o         (tag_o)
  );

  typedef struct {
    logic [W-1:0] d;
    logic [T-1:0] t;
    int           acc;
    int           stl;
  } exp_t;

  exp_t sb[$];
  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;
  int stall_cnt = 0;
  bit prev_stall = 0;
  logic [W-1:0] prev_d;
  logic [T-1:0] prev_t;

  task automatic check(string tag, logic [63:0] act,
                       logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h",
                  tag, act, exp);
  endtask

  // Bit-by-bit reference, deliberately not a shift operator.
  function automatic logic [W-1:0] ref_shift(
    logic [2:0] op, logic [W-1:0] d, int a);
    logic [W-1:0] r;
    r = d;
    for (int i = 0; i < W; i++) begin
      case (op)
        3'd0: r[i] = (i >= a) ? d[(i-a+W)%W] : 1'b0;
        3'd1: r[i] = (i + a < W) ? d[(i+a)%W] : 1'b0;
        3'd2: r[i] = (i + a < W) ? d[(i+a)%W] : d[W-1];
        3'd3: r[i] = d[(i - a + W) % W];
        3'd4: r[i] = d[(i + a) % W];
        default: r[i] = d[i];
      endcase
    end
    return r;
  endfunction

  task automatic step(bit v, logic [2:0] op,
                      logic [W-1:0] d, logic [N-1:0] a,
                      logic [T-1:0] tg, logic [W-1:0] e,
                      bit rdy, bit rst);
    exp_t x;
    valid_i = v; op_i = op; data_i = d;
    shift_value_i = a; tag_i = tg;
    ready_i = rdy; rst_i = rst;
    #1;
    check("ready_o", ready_o, 64'(!valid_o || rdy));
    if (!valid_o) check("zero_idle", data_o, 0);
    if (prev_stall) begin
      check("hold_data", data_o, prev_d);
      check("hold_tag", tag_o, prev_t);
    end
    prev_stall = valid_o && !rdy && !rst;
    prev_d = data_o;
    prev_t = tag_o;
    if (rst) begin
      sb.delete();
    end else begin
      if (valid_o && rdy) begin
        if (sb.size() == 0) begin
          check("unexpected_out", 1, 0);
        end else begin
          x = sb.pop_front();
          check("data_o", data_o, x.d);
          check("tag_o", tag_o, x.t);
          check("latency", cyc - x.acc,
                N + stall_cnt - x.stl);
        end
      end
      if (!ready_o) stall_cnt++;
      if (v && ready_o) begin
        x.d = e; x.t = tg; x.acc = cyc; x.stl = stall_cnt;
        sb.push_back(x);
      end
    end
    @(posedge clk_i);
    #1;
    cyc++;
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 1, 0);
  endtask

  task automatic op_m(logic [2:0] op, logic [W-1:0] d,
                      logic [N-1:0] a, logic [T-1:0] tg,
                      bit rdy);
    step(1, op, d, a, tg, ref_shift(op, d, int'(a)), rdy, 0);
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && sb.size() != 0; i++) idle(1);
    check("drain_empty", sb.size(), 0);
  endtask

  initial begin
    logic [W-1:0] d;
    logic [2:0] op;
    logic [N-1:0] a;
    valid_i = 0; op_i = 0; data_i = 0; shift_value_i = 0;
    tag_i = 0; ready_i = 1; rst_i = 1;
    @(posedge clk_i); #1;
    step(0, 0, 0, 0, 0, 0, 1, 1);
    check("rst_valid_o", valid_o, 0);
    check("rst_data_o", data_o, 0);
    check("rst_tag_o", tag_o, 0);
    check("rst_ready_o", ready_o, 1);

    // directed
    step(1, 3'd0, 32'h1, 5'd31, 5'd3, 32'h8000_0000, 1, 0);
    for (int i = 0; i < 5; i++) begin
      check("t1_ready", ready_o, 1);
      idle(1);
    end
    drain();
    step(1, 3'd2, 32'h8000_0000, 5'd4, 5'd1, 32'hF800_0000, 1, 0);
    step(1, 3'd1, 32'h8000_0000, 5'd4, 5'd2, 32'h0800_0000, 1, 0);
    step(1, 3'd2, 32'h8000_0000, 5'd31, 5'd3, 32'hFFFF_FFFF, 1, 0);
    step(1, 3'd3, 32'h8000_0001, 5'd1, 5'd4, 32'h0000_0003, 1, 0);
    step(1, 3'd4, 32'h0000_0003, 5'd1, 5'd5, 32'h8000_0001, 1, 0);
    step(1, 3'd7, 32'h1234_5678, 5'd9, 5'd6, 32'h1234_5678, 1, 0);
    step(1, 3'd1, 32'h8000_0000, 5'd31, 5'd7, 32'h1, 1, 0);
    step(1, 3'd3, 32'hDEAD_BEEF, 5'd0, 5'd8, 32'hDEAD_BEEF, 1, 0);
    drain();

    // back-to-back stream, tags 0..7
    for (int i = 0; i < 8; i++) begin
      d = $urandom; op = 3'($urandom_range(0, 4));
      a = 5'($urandom);
      op_m(op, d, a, 5'(i), 1);
    end
    drain();

    // backpressure: stall 3 cycles with results waiting
    for (int i = 0; i < 12; i++) begin
      d = $urandom; op = 3'($urandom_range(0, 7));
      a = 5'($urandom);
      if (i < 10) op_m(op, d, a, 5'(10 + i), !(i >= 6 && i < 9));
      else step(0, 0, 0, 0, 0, 0, 1, 0);
    end
    drain();

    // reset with three ops in flight
    for (int i = 0; i < 3; i++)
      op_m(3'd0, 32'h0000_00FF, 5'(i + 1), 5'(20 + i), 1);
    step(1, 3'd0, 32'h5, 5'd1, 5'd30, 32'hA, 1, 1);
    check("post_rst_valid", valid_o, 0);
    check("post_rst_data", data_o, 0);
    op_m(3'd4, 32'h0000_00F0, 5'd4, 5'd25, 1);
    idle(8);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
